// File: rtl/axi_pv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pv_pkg
// Purpose  : Shared definitions for the AXI write-side protocol monitor:
//            error bitmap indices, AXI burst/response encodings and a
//            handshake helper.
// Revision : 1.0 - initial release
// ============================================================================
package axi_pv_pkg;

  // Error bitmap layout (err_code / err_sticky)
  localparam int ERR_W             = 8;
  localparam int ERR_AW_STABLE     = 0;
  localparam int ERR_W_STABLE      = 1;
  localparam int ERR_B_STABLE      = 2;
  localparam int ERR_WLAST_EARLY   = 3;
  localparam int ERR_WLAST_MISSING = 4;
  localparam int ERR_W_NO_AW       = 5;
  localparam int ERR_B_EARLY       = 6;
  localparam int ERR_AW_OVERFLOW   = 7;

  // AXI burst type encodings
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI write response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A transfer happens on a rising edge where both valid and ready are high.
  function automatic logic hs(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_len_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi_len_fifo
// Purpose  : Small synchronous FIFO holding AW burst lengths awaiting W
//            completion. Push while full is accepted only when a pop happens
//            on the same edge.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            i_push / i_din  - write request and data
//            i_pop           - read request (ignored when empty)
//            o_dout          - head entry (valid when !o_empty)
//            o_full/o_empty  - status flags
//            o_count         - number of stored entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module axi_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_wr_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_monitor
// Purpose  : Passive AXI write-channel monitor. Tracks queued AW lengths,
//            beats of the current W burst and completed bursts awaiting B,
//            and reports protocol violations one cycle after they are seen.
// Ports    : axi_aclk/axi_aresetn       - clock, async active-low reset
//            axi_aw*/axi_w*/axi_b*       - observed AW, W and B channels
//            err_clr                     - clears err_sticky (new errors win)
//            err_valid/err_code          - one-cycle violation pulse + bitmap
//            err_sticky                  - accumulated violation bitmap
//            beat_cnt                    - beats accepted in current W burst
//            aw_outstanding              - AW lengths queued
//            b_pending                   - completed bursts awaiting B
//            burst_done                  - pulse after final W beat
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_monitor
  import axi_pv_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 64,
  parameter int MAXOUT = 4
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic [AW-1:0]             axi_awaddr,
  input  logic [7:0]                axi_awlen,
  input  logic [2:0]                axi_awsize,
  input  logic [1:0]                axi_awburst,
  input  logic                      axi_awvalid,
  input  logic                      axi_awready,
  input  logic [DW-1:0]             axi_wdata,
  input  logic [DW/8-1:0]           axi_wstrb,
  input  logic                      axi_wlast,
  input  logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic                      err_clr,
  output logic                      err_valid,
  output logic [7:0]                err_code,
  output logic [7:0]                err_sticky,
  output logic [7:0]                beat_cnt,
  output logic [$clog2(MAXOUT):0]   aw_outstanding,
  output logic [$clog2(MAXOUT):0]   b_pending,
  output logic                      burst_done
);

  localparam int CW  = $clog2(MAXOUT) + 1;
  localparam int AWP = AW + 8 + 3 + 2;
  localparam int WP  = DW + DW/8 + 1;
  localparam logic [CW:0] BP_MAX = (CW+1)'(MAXOUT);

  // Handshakes
  logic w_aw_hs, w_w_hs, w_b_hs;
  assign w_aw_hs = hs(axi_awvalid, axi_awready);
  assign w_w_hs  = hs(axi_wvalid,  axi_wready);
  assign w_b_hs  = hs(axi_bvalid,  axi_bready);

  // Stability history: stall flag and payload from the previous cycle
  logic [AWP-1:0] w_aw_pay, r_aw_pay;
  logic [WP-1:0]  w_w_pay,  r_w_pay;
  logic [1:0]     r_b_pay;
  logic           r_aw_stall, r_w_stall, r_b_stall;
  assign w_aw_pay = {axi_awaddr, axi_awlen, axi_awsize, axi_awburst};
  assign w_w_pay  = {axi_wdata, axi_wstrb, axi_wlast};

  // Burst length tracking
  logic            w_fifo_empty, w_fifo_full;
  logic [7:0]      w_head, w_len;
  logic            w_have_len, w_bypass, w_w_beat, w_len_match, w_last_beat;
  logic            w_pop, w_push_req, w_push, w_overflow;
  logic [7:0]      r_beat_cnt, w_beat_next;

  // Completed bursts awaiting B
  logic [CW-1:0]   r_b_pending, w_bp_next;
  logic [CW:0]     w_bp_sum;
  logic            w_b_dec;

  logic [ERR_W-1:0] w_err;
  logic             r_err_valid, r_burst_done;
  logic [ERR_W-1:0] r_err_code, r_err_sticky;

  // With an empty queue, a same-cycle AW supplies the length directly.
  assign w_bypass    = w_fifo_empty && w_aw_hs;
  assign w_have_len  = !w_fifo_empty || w_aw_hs;
  assign w_len       = w_fifo_empty ? axi_awlen : w_head;
  assign w_w_beat    = w_w_hs && w_have_len;
  assign w_len_match = (r_beat_cnt == w_len);
  assign w_last_beat = w_w_beat && w_len_match;
  assign w_pop       = w_last_beat && !w_fifo_empty;
  // A bypassed AW whose single burst also finishes this edge is consumed
  // immediately and never enters the queue.
  assign w_push_req  = w_aw_hs && !(w_bypass && w_last_beat);
  assign w_overflow  = w_push_req && w_fifo_full && !w_pop;
  assign w_push      = w_push_req && !w_overflow;

  assign w_beat_next = w_last_beat ? 8'd0 :
                       w_w_beat    ? r_beat_cnt + 8'd1 : r_beat_cnt;

  assign w_b_dec = w_b_hs && (r_b_pending != '0);

  always_comb begin
    w_bp_sum  = {1'b0, r_b_pending} + {{CW{1'b0}}, w_last_beat}
              - {{CW{1'b0}}, w_b_dec};
    w_bp_next = (w_bp_sum > BP_MAX) ? BP_MAX[CW-1:0] : w_bp_sum[CW-1:0];
  end

  always_comb begin
    w_err = '0;
    w_err[ERR_AW_STABLE]     = r_aw_stall && (!axi_awvalid || (w_aw_pay != r_aw_pay));
    w_err[ERR_W_STABLE]      = r_w_stall  && (!axi_wvalid  || (w_w_pay  != r_w_pay));
    w_err[ERR_B_STABLE]      = r_b_stall  && (!axi_bvalid  || (axi_bresp != r_b_pay));
    w_err[ERR_WLAST_EARLY]   = w_w_beat && !w_len_match && axi_wlast;
    w_err[ERR_WLAST_MISSING] = w_last_beat && !axi_wlast;
    w_err[ERR_W_NO_AW]       = w_w_hs && !w_have_len;
    w_err[ERR_B_EARLY]       = axi_bvalid && (r_b_pending == '0);
    w_err[ERR_AW_OVERFLOW]   = w_overflow;
  end

  axi_len_fifo #(
    .DEPTH (MAXOUT),
    .WIDTH (8)
  ) u_len_fifo (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .i_push  (w_push),
    .i_din   (axi_awlen),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (aw_outstanding)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_err_valid  <= 1'b0;
      r_err_code   <= '0;
      r_err_sticky <= '0;
      r_beat_cnt   <= '0;
      r_b_pending  <= '0;
      r_burst_done <= 1'b0;
      r_aw_stall   <= 1'b0;
      r_w_stall    <= 1'b0;
      r_b_stall    <= 1'b0;
      r_aw_pay     <= '0;
      r_w_pay      <= '0;
      r_b_pay      <= '0;
    end else begin
      r_err_valid  <= |w_err;
      r_err_code   <= w_err;
      r_err_sticky <= (err_clr ? '0 : r_err_sticky) | w_err;
      r_beat_cnt   <= w_beat_next;
      r_b_pending  <= w_bp_next;
      r_burst_done <= w_last_beat;
      r_aw_stall   <= axi_awvalid && !axi_awready;
      r_w_stall    <= axi_wvalid  && !axi_wready;
      r_b_stall    <= axi_bvalid  && !axi_bready;
      r_aw_pay     <= w_aw_pay;
      r_w_pay      <= w_w_pay;
      r_b_pay      <= axi_bresp;
    end
  end

  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;
  assign err_sticky = r_err_sticky;
  assign beat_cnt   = r_beat_cnt;
  assign b_pending  = r_b_pending;
  assign burst_done = r_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_monitor
// Purpose  : Self-checking bench for axi_wr_monitor: directed scenarios with
//            literal expectations plus a randomized run against a queue-based
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wr_monitor;

  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int MAXOUT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [2:0]      awsize = '0;
  logic [1:0]      awburst = '0;
  logic            awvalid = 1'b0, awready = 1'b0;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wlast = 1'b0, wvalid = 1'b0, wready = 1'b0;
  logic [1:0]      bresp = '0;
  logic            bvalid = 1'b0, bready = 1'b0;
  logic            err_clr = 1'b0;

  logic            err_valid;
  logic [7:0]      err_code, err_sticky, beat_cnt;
  logic [2:0]      aw_outstanding, b_pending;
  logic            burst_done;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  axi_wr_monitor #(.AW(AW), .DW(DW), .MAXOUT(MAXOUT)) dut (
    .axi_aclk       (clk),
    .axi_aresetn    (rst_n),
    .axi_awaddr     (awaddr),
    .axi_awlen      (awlen),
    .axi_awsize     (awsize),
    .axi_awburst    (awburst),
    .axi_awvalid    (awvalid),
    .axi_awready    (awready),
    .axi_wdata      (wdata),
    .axi_wstrb      (wstrb),
    .axi_wlast      (wlast),
    .axi_wvalid     (wvalid),
    .axi_wready     (wready),
    .axi_bresp      (bresp),
    .axi_bvalid     (bvalid),
    .axi_bready     (bready),
    .err_clr        (err_clr),
    .err_valid      (err_valid),
    .err_code       (err_code),
    .err_sticky     (err_sticky),
    .beat_cnt       (beat_cnt),
    .aw_outstanding (aw_outstanding),
    .b_pending      (b_pending),
    .burst_done     (burst_done)
  );

  // ---------------- reference model ----------------
  int          lenq[$];
  int          m_beat, m_bp;
  logic [7:0]  m_sticky, x_code;
  bit          x_done;
  bit          m_aw_stall, m_w_stall, m_b_stall;
  logic [AW+12:0]       m_aw_pay;
  logic [DW+DW/8:0]     m_w_pay;
  logic [1:0]           m_b_pay;

  task automatic model_reset();
    lenq.delete();
    m_beat = 0; m_bp = 0; m_sticky = '0; x_code = '0; x_done = 0;
    m_aw_stall = 0; m_w_stall = 0; m_b_stall = 0;
    m_aw_pay = '0; m_w_pay = '0; m_b_pay = '0;
  endtask

  // Applies the rules to the inputs present before the coming edge.
  task automatic model_eval();
    logic [7:0] c;
    bit aw_hs, w_hs, b_hs, done, from_q, have;
    int len, pre, dec;
    c = '0; done = 0; from_q = 0; have = 0; len = 0;
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    b_hs  = bvalid && bready;
    if (m_aw_stall && (!awvalid || {awaddr, awlen, awsize, awburst} !== m_aw_pay)) c[0] = 1'b1;
    if (m_w_stall  && (!wvalid  || {wdata, wstrb, wlast} !== m_w_pay))             c[1] = 1'b1;
    if (m_b_stall  && (!bvalid  || bresp !== m_b_pay))                             c[2] = 1'b1;
    if (w_hs) begin
      if (lenq.size() != 0) begin len = lenq[0]; have = 1; from_q = 1; end
      else if (aw_hs)       begin len = int'(awlen); have = 1; end
      else c[5] = 1'b1;
      if (have) begin
        if (m_beat == len) begin
          if (!wlast) c[4] = 1'b1;
          done = 1;
        end else begin
          if (wlast) c[3] = 1'b1;
          m_beat++;
        end
      end
    end
    if (bvalid && m_bp == 0) c[6] = 1'b1;
    pre = lenq.size();
    if (done && from_q) void'(lenq.pop_front());
    if (aw_hs && !(done && !from_q)) begin
      if (pre == MAXOUT && !(done && from_q)) c[7] = 1'b1;
      else lenq.push_back(int'(awlen));
    end
    if (done) m_beat = 0;
    dec = (b_hs && m_bp > 0) ? 1 : 0;
    m_bp = m_bp + int'(done) - dec;
    if (m_bp > MAXOUT) m_bp = MAXOUT;
    m_sticky = (err_clr ? 8'h00 : m_sticky) | c;
    x_code = c;
    x_done = done;
    m_aw_stall = awvalid && !awready;
    m_w_stall  = wvalid && !wready;
    m_b_stall  = bvalid && !bready;
    m_aw_pay = {awaddr, awlen, awsize, awburst};
    m_w_pay  = {wdata, wstrb, wlast};
    m_b_pay  = bresp;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; err_clr = 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    n_total++;
    if ({err_valid, err_code, err_sticky, burst_done} !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_err: got ev=%b code=%h sticky=%h done=%b want all 0",
               err_valid, err_code, err_sticky, burst_done);
    end
    n_total++;
    if ({beat_cnt, aw_outstanding, b_pending} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_cnt: got beat=%0d aw=%0d bp=%0d want 0 0 0",
               beat_cnt, aw_outstanding, b_pending);
    end
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_basic_burst();
    do_reset();
    awvalid = 1; awready = 1; awlen = 8'd3; awaddr = $urandom; awsize = 3'd3; awburst = 2'b01;
    tick();
    n_total++;
    if (aw_outstanding !== 3'd1) begin
      n_bad++; $display("FAIL basic_aw_out: got %0d want 1", aw_outstanding);
    end
    awvalid = 0; wvalid = 1; wready = 1; wstrb = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      wdata = {$urandom, $urandom};
      wlast = (i == 3);
      tick();
      n_total++;
      if (beat_cnt !== ((i == 3) ? 8'd0 : 8'(i + 1)) || burst_done !== (i == 3)) begin
        n_bad++;
        $display("FAIL basic_beat%0d: got beat=%0d done=%b want beat=%0d done=%b",
                 i, beat_cnt, burst_done, (i == 3) ? 0 : i + 1, (i == 3));
      end
    end
    n_total++;
    if (b_pending !== 3'd1 || aw_outstanding !== 3'd0) begin
      n_bad++; $display("FAIL basic_bp1: got bp=%0d aw=%0d want 1 0", b_pending, aw_outstanding);
    end
    wvalid = 0; wlast = 0; bvalid = 1; bready = 1; bresp = 2'b00;
    tick();
    n_total++;
    if (b_pending !== 3'd0 || burst_done !== 1'b0) begin
      n_bad++; $display("FAIL basic_bp0: got bp=%0d done=%b want 0 0", b_pending, burst_done);
    end
    bvalid = 0;
    tick();
    n_total++;
    if (err_sticky !== 8'h00) begin
      n_bad++; $display("FAIL basic_clean: got sticky=%h want 00", err_sticky);
    end
  endtask

  task automatic test_aw_stable();
    do_reset();
    awvalid = 1; awready = 0; awaddr = 32'h100; awlen = 8'd0;
    tick();
    awaddr = 32'h104;
    tick();
    n_total++;
    if (err_valid !== 1'b1 || err_code !== 8'h01 || err_sticky !== 8'h01) begin
      n_bad++; $display("FAIL aw_stable: got ev=%b code=%h sticky=%h want 1 01 01",
                        err_valid, err_code, err_sticky);
    end
    tick();
    n_total++;
    if (err_valid !== 1'b0 || err_sticky !== 8'h01) begin
      n_bad++; $display("FAIL aw_stable_pulse: got ev=%b sticky=%h want 0 01", err_valid, err_sticky);
    end
    err_clr = 1;
    tick();
    n_total++;
    if (err_sticky !== 8'h00) begin
      n_bad++; $display("FAIL err_clr: got sticky=%h want 00", err_sticky);
    end
    awaddr = 32'h108;
    tick();
    n_total++;
    if (err_sticky !== 8'h01 || err_code !== 8'h01) begin
      n_bad++; $display("FAIL clr_set_wins: got sticky=%h code=%h want 01 01", err_sticky, err_code);
    end
    err_clr = 0;
  endtask

  task automatic test_wlast_errors();
    do_reset();
    awvalid = 1; awready = 1; awlen = 8'd1;
    tick();
    awvalid = 0; wvalid = 1; wready = 1; wlast = 1;
    tick();
    n_total++;
    if (err_code !== 8'h08 || beat_cnt !== 8'd1) begin
      n_bad++; $display("FAIL wlast_early: got code=%h beat=%0d want 08 1", err_code, beat_cnt);
    end
    wlast = 0;
    tick();
    n_total++;
    if (err_code !== 8'h10 || burst_done !== 1'b1 || b_pending !== 3'd1 || beat_cnt !== 8'd0) begin
      n_bad++; $display("FAIL wlast_missing: got code=%h done=%b bp=%0d beat=%0d want 10 1 1 0",
                        err_code, burst_done, b_pending, beat_cnt);
    end
    wvalid = 0;
  endtask

  task automatic test_no_aw_b_early();
    do_reset();
    wvalid = 1; wready = 1; wlast = 1;
    tick();
    n_total++;
    if (err_code !== 8'h20 || beat_cnt !== 8'd0 || burst_done !== 1'b0) begin
      n_bad++; $display("FAIL w_no_aw: got code=%h beat=%0d done=%b want 20 0 0",
                        err_code, beat_cnt, burst_done);
    end
    wvalid = 0; wlast = 0; bvalid = 1; bready = 1;
    tick();
    n_total++;
    if (err_code !== 8'h40 || b_pending !== 3'd0) begin
      n_bad++; $display("FAIL b_early: got code=%h bp=%0d want 40 0", err_code, b_pending);
    end
    bvalid = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    awvalid = 1; awready = 1; awlen = 8'd0;
    for (int i = 0; i < 4; i++) begin
      awaddr = 32'(i * 16);
      tick();
    end
    n_total++;
    if (aw_outstanding !== 3'd4 || err_sticky !== 8'h00) begin
      n_bad++; $display("FAIL ovf_fill: got aw=%0d sticky=%h want 4 00", aw_outstanding, err_sticky);
    end
    tick();
    n_total++;
    if (err_code !== 8'h80 || aw_outstanding !== 3'd4) begin
      n_bad++; $display("FAIL ovf_fifth: got code=%h aw=%0d want 80 4", err_code, aw_outstanding);
    end
    wvalid = 1; wready = 1; wlast = 1;
    tick();
    n_total++;
    if (err_valid !== 1'b0 || aw_outstanding !== 3'd4 || burst_done !== 1'b1) begin
      n_bad++; $display("FAIL full_push_pop: got ev=%b aw=%0d done=%b want 0 4 1",
                        err_valid, aw_outstanding, burst_done);
    end
    idle();
  endtask

  task automatic test_bypass_same_edge();
    do_reset();
    awvalid = 1; awready = 1; awlen = 8'd0;
    wvalid = 1; wready = 1; wlast = 1;
    bvalid = 1; bready = 1;
    tick();
    n_total++;
    if (err_code !== 8'h40 || b_pending !== 3'd1 || aw_outstanding !== 3'd0 || burst_done !== 1'b1) begin
      n_bad++; $display("FAIL bypass_b_same: got code=%h bp=%0d aw=%0d done=%b want 40 1 0 1",
                        err_code, b_pending, aw_outstanding, burst_done);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    awvalid = 1; awready = 1; awlen = 8'd3;
    tick();
    awvalid = 0; wvalid = 1; wready = 1; wlast = 0;
    repeat (2) tick();
    wvalid = 0; awvalid = 1; awready = 0;
    tick();
    n_total++;
    if (beat_cnt !== 8'd2 || aw_outstanding !== 3'd1) begin
      n_bad++; $display("FAIL mid_pre: got beat=%0d aw=%0d want 2 1", beat_cnt, aw_outstanding);
    end
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    n_total++;
    if ({err_valid, err_code, err_sticky, beat_cnt, aw_outstanding, b_pending, burst_done} !== 32'h0) begin
      n_bad++; $display("FAIL mid_async: got beat=%0d aw=%0d bp=%0d code=%h want all 0",
                        beat_cnt, aw_outstanding, b_pending, err_code);
    end
    idle();
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    tick();
    n_total++;
    if (err_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_post_stab: got ev=%b code=%h want 0", err_valid, err_code);
    end
    awvalid = 1; awready = 1; awlen = 8'd0;
    tick();
    awvalid = 0; wvalid = 1; wready = 1; wlast = 1;
    tick();
    wvalid = 0; wlast = 0; bvalid = 1; bready = 1;
    tick();
    bvalid = 0;
    tick();
    n_total++;
    if (err_sticky !== 8'h00 || b_pending !== 3'd0 || beat_cnt !== 8'd0) begin
      n_bad++; $display("FAIL mid_new_burst: got sticky=%h bp=%0d beat=%0d want 00 0 0",
                        err_sticky, b_pending, beat_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] act, exp;
    do_reset();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (!(m_aw_stall && $urandom_range(0, 9) != 0)) begin
        awvalid = ($urandom_range(0, 9) < 5);
        awaddr  = $urandom;
        awlen   = 8'($urandom_range(0, 3));
        awsize  = 3'($urandom);
        awburst = 2'($urandom);
      end
      awready = ($urandom_range(0, 9) < 6);
      if (!(m_w_stall && $urandom_range(0, 9) != 0)) begin
        wvalid = ($urandom_range(0, 9) < 6);
        wdata  = {$urandom, $urandom};
        wstrb  = 8'($urandom);
        wlast  = ($urandom_range(0, 2) == 0);
      end
      wready = ($urandom_range(0, 9) < 7);
      if (!(m_b_stall && $urandom_range(0, 9) != 0)) begin
        bvalid = ($urandom_range(0, 9) < 3);
        bresp  = 2'($urandom);
      end
      bready  = ($urandom_range(0, 9) < 6);
      err_clr = ($urandom_range(0, 15) == 0);
      tick();
      act = {err_valid, err_code, err_sticky, beat_cnt, aw_outstanding, b_pending, burst_done};
      exp = {(x_code != 8'h00), x_code, m_sticky, 8'(m_beat), 3'(lenq.size()), 3'(m_bp), x_done};
      n_total++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL random_cyc%0d: got %h want %h (ev,code,sticky,beat,aw,bp,done)", cyc, act, exp);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_burst();
    test_aw_stable();
    test_wlast_errors();
    test_no_aw_b_early();
    test_overflow();
    test_bypass_same_edge();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
